// File: rtl/memory_tank_sequencer.sv
// Timing/access controller for the mercury delay-line store.
// Runs the pulse-position (digit) and minor-cycle counters, accepts one access at a time,
// waits for the addressed short word to reach the tank output and gates that tank's
// clr/in/out lines for one short word (or one long word).
// Optional feature: define MEMORY_SEQ_WAITCNT_EN to add the wait_cycles output.
module memory_tank_sequencer #(
    parameter int unsigned WORD_BITS   = 18,
    parameter int unsigned SHORT_WORDS = 32,
    parameter int unsigned NUM_TANKS   = 16,
    localparam int unsigned TANK_W  = $clog2(NUM_TANKS),
    localparam int unsigned WORD_W  = $clog2(SHORT_WORDS),
    localparam int unsigned ADDR_W  = TANK_W + WORD_W,
    localparam int unsigned DIGIT_W = $clog2(WORD_BITS)
) (
    input  logic                 r1_clk,
    input  logic                 r1_rst_n,
    input  logic                 req,
    input  logic                 wr,
    input  logic                 long_w,
    input  logic [ADDR_W-1:0]    addr,
    output logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_TANKS-1:0] tank_out,
    output logic [NUM_TANKS-1:0] tank_in,
    output logic [NUM_TANKS-1:0] tank_clr,
    output logic [DIGIT_W-1:0]   digit_cnt,
    output logic [WORD_W-1:0]    minor_cnt,
    output logic                 word_strobe
`ifdef MEMORY_SEQ_WAITCNT_EN
    ,
    output logic [9:0]           wait_cycles
`endif
);

    localparam int unsigned XFER_W = $clog2(2 * WORD_BITS);
    localparam logic [DIGIT_W-1:0] DigitMax  = DIGIT_W'(WORD_BITS - 1);
    localparam logic [XFER_W-1:0]  ShortLast = XFER_W'(WORD_BITS - 1);
    localparam logic [XFER_W-1:0]  LongLast  = XFER_W'(2 * WORD_BITS - 1);

    typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

    state_e               state_q, state_d;
    logic [DIGIT_W-1:0]   digit_q, digit_d;
    logic [WORD_W-1:0]    minor_q, minor_d;
    logic [XFER_W-1:0]    xfer_cnt_q;
    logic [TANK_W-1:0]    tank_q;
    logic [WORD_W-1:0]    word_q;
    logic                 wr_q, long_q;
    logic [NUM_TANKS-1:0] out_q, out_d, in_q, in_d, clr_q, clr_d;

    logic                 digit_wrap;
    logic [WORD_W-1:0]    req_word;
    logic                 start_xfer;
    logic [TANK_W-1:0]    sel_tank;
    logic                 sel_wr;
    logic [NUM_TANKS-1:0] sel_onehot;

    // Free-running counter next state; minor advances on the digit wrap
    always_comb begin
        digit_wrap = (digit_q == DigitMax);
        digit_d    = digit_wrap ? '0 : digit_q + 1'b1;
        minor_d    = digit_wrap ? minor_q + 1'b1 : minor_q;
    end

    // Requested word, LSB forced low for long words
    assign req_word = addr[WORD_W-1:0] & ~WORD_W'(long_w);

    // FSM next state; the match looks one cycle ahead so the registered gates open exactly
    // on the cycle the addressed word appears at the tank output
    always_comb begin
        state_d    = state_q;
        ack        = 1'b0;
        start_xfer = 1'b0;
        unique case (state_q)
            StIdle: begin
                // ack held low while reset is asserted so every output reads 0
                if (req && r1_rst_n) begin
                    ack = 1'b1;
                    if (digit_d == '0 && minor_d == req_word) begin
                        state_d    = StXfer;
                        start_xfer = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (digit_d == '0 && minor_d == word_q) begin
                    state_d    = StXfer;
                    start_xfer = 1'b1;
                end
            end
            StXfer: begin
                if (xfer_cnt_q == (long_q ? LongLast : ShortLast)) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Gate next state: on acceptance cycle the request inputs are used, afterwards the latches
    always_comb begin
        sel_tank   = (state_q == StIdle) ? addr[ADDR_W-1:WORD_W] : tank_q;
        sel_wr     = (state_q == StIdle) ? wr : wr_q;
        sel_onehot = NUM_TANKS'(1) << sel_tank;
        out_d      = '0;
        in_d       = '0;
        clr_d      = '0;
        if (state_d == StXfer) begin
            if (sel_wr) begin
                in_d  = sel_onehot;
                clr_d = sel_onehot;
            end else begin
                out_d = sel_onehot;
            end
        end
    end

    // Counters, FSM state, request latches and gate registers
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            state_q    <= StIdle;
            digit_q    <= '0;
            minor_q    <= '0;
            xfer_cnt_q <= '0;
            tank_q     <= '0;
            word_q     <= '0;
            wr_q       <= 1'b0;
            long_q     <= 1'b0;
            out_q      <= '0;
            in_q       <= '0;
            clr_q      <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            minor_q <= minor_d;
            out_q   <= out_d;
            in_q    <= in_d;
            clr_q   <= clr_d;
            if (start_xfer) begin
                xfer_cnt_q <= '0;
            end else if (state_q == StXfer) begin
                xfer_cnt_q <= xfer_cnt_q + 1'b1;
            end
            if (ack) begin
                tank_q <= addr[ADDR_W-1:WORD_W];
                word_q <= req_word;
                wr_q   <= wr;
                long_q <= long_w;
            end
        end
    end

    assign busy        = (state_q == StWait) || (state_q == StXfer);
    assign done        = (state_q == StDone);
    assign tank_out    = out_q;
    assign tank_in     = in_q;
    assign tank_clr    = clr_q;
    assign digit_cnt   = digit_q;
    assign minor_cnt   = minor_q;
    assign word_strobe = (digit_q == '0) && r1_rst_n;

`ifdef MEMORY_SEQ_WAITCNT_EN
    logic [9:0] wait_cnt_q, wait_cycles_q;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3ff) ? v : v + 10'd1;
    endfunction

    // Cycles from acceptance to transfer start; wait_cnt_q equals cycles elapsed since ack
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            wait_cnt_q    <= '0;
            wait_cycles_q <= '0;
        end else begin
            if (ack) begin
                wait_cnt_q <= 10'd1;
            end else if (state_q == StWait) begin
                wait_cnt_q <= sat_inc(wait_cnt_q);
            end
            if (start_xfer) begin
                wait_cycles_q <= (state_q == StIdle) ? 10'd1 : sat_inc(wait_cnt_q);
            end
        end
    end

    assign wait_cycles = wait_cycles_q;
`endif

endmodule
